// File: rtl/int_ram_pkg.sv
// Shared types and saturating-add helper for the banked intrinsic-message RAM.
package int_ram_pkg;

    typedef enum logic {CLEAR, RUN} clr_state_e;

    typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE, OP_ACC} op_e;

    localparam int DEF_DATA_WIDTH = 5;
    localparam int DEF_SAT_MAX    = (1 << (DEF_DATA_WIDTH - 1)) - 1;
    localparam int DEF_SAT_MIN    = -DEF_SAT_MAX;

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Symmetric clamp: the most negative code is never produced by an accumulate.
    function automatic int sat_add(input int a, input int b, input int dw);
        int s;
        int lim;
        s   = a + b;
        lim = sat_max(dw);
        if (s > lim)  return lim;
        if (s < -lim) return -lim;
        return s;
    endfunction

endpackage

// File: rtl/int_ram_bank.sv
// One 1R1W bank: op decode, writeback register with forwarding, registered read port.
module int_ram_bank
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  acc,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid
);

    op_e                   op;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  wb_vld;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] acc_res;

    always_comb begin
        op = OP_IDLE;
        if (cs) op = !we ? OP_READ : (acc ? OP_ACC : OP_WRITE);
    end

    // The pending writeback has not reached the array yet, so it wins on an address hit.
    assign cur     = (wb_vld && wb_addr == address) ? wb_data : mem[address];
    assign acc_res = DATA_WIDTH'(sat_add(int'($signed(cur)), int'($signed(data_in)), DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (wb_vld) mem[wb_addr] <= wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_vld   <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            wb_vld   <= (op == OP_WRITE) || (op == OP_ACC);
            wb_addr  <= address;
            wb_data  <= (op == OP_ACC) ? acc_res : data_in;
            rd_valid <= (op == OP_READ);
            if (op == OP_READ) data_out <= cur;
        end
    end

endmodule

// File: rtl/int_ram_banked.sv
// NUM_BANKS independent message banks behind one address, plus the clear sweep
// that zeroes every bank after reset or on clear_req.
module int_ram_banked
    import int_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_BANKS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in  [0:NUM_BANKS-1],
    input  logic [NUM_BANKS-1:0]  we,
    input  logic [NUM_BANKS-1:0]  cs,
    input  logic [NUM_BANKS-1:0]  acc,
    output logic [DATA_WIDTH-1:0] data_out [0:NUM_BANKS-1],
    output logic [NUM_BANKS-1:0]  rd_valid
);

    clr_state_e            state, state_nxt;
    logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_nxt;
    logic [ADDR_WIDTH-1:0] bank_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_cnt;
        case (state)
            CLEAR: begin
                sweep_nxt = sweep_cnt + 1'b1;
                if (sweep_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                    state_nxt = RUN;
                    sweep_nxt = '0;
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    sweep_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy      = (state == CLEAR);
    assign bank_addr = busy ? sweep_cnt : address;

    // While sweeping, every bank sees a plain write of zero at the sweep address.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        int_ram_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .RAM_DEPTH (RAM_DEPTH)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .address (bank_addr),
            .data_in (busy ? '0 : data_in[b]),
            .cs      (busy | cs[b]),
            .we      (busy | we[b]),
            .acc     (!busy & acc[b]),
            .data_out(data_out[b]),
            .rd_valid(rd_valid[b])
        );
    end

endmodule

// File: tb/tb_int_ram_banked.sv
// Randomized and directed bench for int_ram_banked against a sequential array model.
module tb_int_ram_banked;

    localparam int DW    = 5;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int NB    = 2;
    localparam int LIM   = 15;

    localparam int IDLE = 0, RD = 1, WR = 2, AC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_req = 1'b0;
    logic          busy;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in  [0:NB-1];
    logic [NB-1:0] we = '0, cs = '0, acc = '0;
    logic [DW-1:0] data_out [0:NB-1];
    logic [NB-1:0] rd_valid;

    int n_chk = 0;
    int n_err = 0;
    int model [NB][DEPTH];
    int exp_q [NB];
    int op    [NB];
    int din   [NB];
    int a;

    int_ram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .NUM_BANKS(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_req(clear_req),
        .busy     (busy),
        .address  (address),
        .data_in  (data_in),
        .we       (we),
        .cs       (cs),
        .acc      (acc),
        .data_out (data_out),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int s);
        if (s > LIM)  return LIM;
        if (s < -LIM) return -LIM;
        return s;
    endfunction

    task automatic zero_model();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < DEPTH; i++) model[b][i] = 0;
    endtask

    task automatic drive_idle();
        cs = '0; we = '0; acc = '0; clear_req = 1'b0;
    endtask

    task automatic set_op(input int o0, input int o1, input int d0, input int d1, input int ad);
        op[0] = o0; op[1] = o1; din[0] = d0; din[1] = d1; a = ad;
    endtask

    // One cycle: drive op[]/din[]/a, apply to the model in program order, check next edge.
    task automatic tick(input string tag);
        int exp_v [NB];
        address = AW'(a);
        for (int b = 0; b < NB; b++) begin
            cs[b]      = (op[b] != IDLE);
            we[b]      = (op[b] >= WR);
            acc[b]     = (op[b] == AC);
            data_in[b] = DW'(din[b]);
            exp_v[b]   = 0;
            case (op[b])
                RD: begin exp_q[b] = model[b][a]; exp_v[b] = 1; end
                WR: model[b][a] = din[b];
                AC: model[b][a] = clamp(model[b][a] + din[b]);
                default: ;
            endcase
        end
        @(posedge clk); #1;
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s_vld%0d", tag, b), int'(rd_valid[b]), exp_v[b]);
            chk($sformatf("%s_q%0d", tag, b), int'($signed(data_out[b])), exp_q[b]);
        end
    endtask

    // Runs random junk (ops and clear_req) while busy; nothing may be accepted.
    task automatic sweep_cycles(input int maxn, output int n);
        n = 0;
        while (busy && n < maxn) begin
            cs        = NB'($urandom);
            we        = NB'($urandom);
            acc       = NB'($urandom);
            clear_req = 1'($urandom);
            address   = AW'($urandom);
            for (int b = 0; b < NB; b++) data_in[b] = DW'($urandom);
            @(posedge clk); #1;
            n++;
            for (int b = 0; b < NB; b++) begin
                chk($sformatf("sweep_vld%0d", b), int'(rd_valid[b]), 0);
                chk($sformatf("sweep_q%0d", b), int'($signed(data_out[b])), exp_q[b]);
            end
        end
        drive_idle();
    endtask

    initial begin
        int n;
        for (int b = 0; b < NB; b++) begin data_in[b] = '0; exp_q[b] = 0; end
        zero_model();

        #12;
        chk("rst_busy", int'(busy), 1);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("rst_vld%0d", b), int'(rd_valid[b]), 0);
            chk($sformatf("rst_q%0d", b), int'($signed(data_out[b])), 0);
        end

        @(negedge clk) rst_n = 1'b1;
        sweep_cycles(2000, n);
        chk("busy_len", n, DEPTH);
        chk("busy_low", int'(busy), 0);

        set_op(RD, RD, 0, 0, 255);    tick("rd_ff");

        set_op(WR, IDLE, 7, 0, 3);    tick("wr7");
        set_op(RD, IDLE, 0, 0, 3);    tick("fwd7");

        set_op(IDLE, AC, 0, 9, 5);    tick("acc1");
        set_op(IDLE, AC, 0, 9, 5);    tick("acc2");
        set_op(IDLE, AC, 0, 9, 5);    tick("acc3");
        set_op(IDLE, IDLE, 0, 0, 5);  tick("gap");
        set_op(IDLE, RD, 0, 0, 5);    tick("acc_rd");

        set_op(WR, WR, -15, -15, 2);  tick("wrn15");
        set_op(AC, AC, -8, -8, 2);    tick("accn8");
        set_op(RD, RD, 0, 0, 2);      tick("neg_rd");

        set_op(WR, WR, 4, -3, 10);    tick("pre10");
        set_op(IDLE, IDLE, 0, 0, 10); tick("gap10");
        set_op(RD, WR, 0, 11, 10);    tick("mix10");
        set_op(RD, RD, 0, 0, 10);     tick("post10");

        for (int i = 0; i < 1500; i++) begin
            a = $urandom_range(0, 7);
            for (int b = 0; b < NB; b++) begin
                op[b]  = $urandom_range(0, 3);
                din[b] = $urandom_range(0, 31) - 16;
            end
            tick("rnd");
        end

        // Leave nonzero read data on the outputs, then clear and reset mid-sweep.
        set_op(WR, WR, 6, -6, 1);     tick("pre_clr_wr");
        set_op(RD, RD, 0, 0, 1);      tick("pre_clr_rd");
        drive_idle();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        chk("clr_busy", int'(busy), 1);
        sweep_cycles(100, n);
        chk("part_len", n, 100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 1);
        for (int b = 0; b < NB; b++) begin
            exp_q[b] = 0;
            chk($sformatf("mid_rst_vld%0d", b), int'(rd_valid[b]), 0);
            chk($sformatf("mid_rst_q%0d", b), int'($signed(data_out[b])), 0);
        end
        zero_model();
        @(negedge clk) rst_n = 1'b1;
        sweep_cycles(2000, n);
        chk("busy_len2", n, DEPTH);

        set_op(RD, RD, 0, 0, 1);      tick("post_clr1");
        set_op(RD, RD, 0, 0, 5);      tick("post_clr5");
        set_op(RD, RD, 0, 0, 255);    tick("post_clr255");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/int_ram_banked.md
# int_ram_banked

Parametrised successor to the two-bank intrinsic-message RAM used by the LDPC decoder. It provides NUM_BANKS independent 1R1W banks behind one shared address. Per-bank write and chip-select are kept, and two things are added: a saturating read-modify-write accumulate mode and a hardware clear sequencer. Check-node and variable-node units use it to accumulate signed messages in place.

## Interface
- DATA_WIDTH, 5, signed message width per entry
- ADDR_WIDTH, 8, address width
- RAM_DEPTH, 1 << ADDR_WIDTH, entries per bank
- NUM_BANKS, 2, number of banks, ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear_req  in  1  one-cycle pulse; zero all banks
- busy  out  1  clear sweep in progress; all bank ops ignored
- address  in  ADDR_WIDTH  shared address for all banks
- data_in  in  [DATA_WIDTH-1:0] [0:NUM_BANKS-1]  write or addend data per bank
- we  in  NUM_BANKS  per-bank write enable
- cs  in  NUM_BANKS  per-bank chip select
- acc  in  NUM_BANKS  per-bank accumulate (only meaningful with cs=we=1)
- data_out  out  [DATA_WIDTH-1:0] [0:NUM_BANKS-1]  registered read data
- rd_valid  out  NUM_BANKS  data_out[b] updated this cycle

## Operation
- Per-bank op at cycle t, decoded from cs/we/acc:
  - cs=0: idle.
  - cs=1, we=0: read.
  - cs=1, we=1, acc=0: write.
  - cs=1, we=1, acc=1: accumulate.
- Read: data_out[b] = mem[address] at t+1; rd_valid[b]=1 for that cycle only. Otherwise data_out[b] holds its last value.
- All writes pass through a per-bank writeback stage and commit to the array at the t+1 edge.
  - Write: commits data_in.
  - Accumulate: reads mem[address] at t and commits sat(mem + data_in) at t+1.
- Saturation is symmetric: the result is clamped to [-(2^(DATA_WIDTH-1)-1), +(2^(DATA_WIDTH-1)-1)], i.e. ±15 at default width. Operands are sign-extended by 1 bit before the add.
- Forwarding: if a read or accumulate at t+1 hits the same bank and address as the op pending writeback, it uses the pending value. Back-to-back accumulates to one address therefore chain correctly.
- Writes and accumulates do not update data_out. rd_valid stays 0.
- Clear FSM states: CLEAR, RUN.
  - After reset release the FSM is in CLEAR. It sweeps addresses 0..RAM_DEPTH-1, writing 0 to every bank, one address per cycle.
  - On the last address it moves to RUN.
  - clear_req in RUN moves to CLEAR next cycle and restarts the sweep at 0.
- While busy=1, cs/we/acc and clear_req are ignored.
- A writeback already pending when clear starts still commits. The sweep then overwrites it.
- Reset mid-sweep or mid-op: the pending writeback is discarded, the sweep counter goes to 0, and the FSM returns to CLEAR.

## Timing
- Reset values: data_out = 0 for all banks, rd_valid = 0, busy = 1, sweep counter = 0, writeback-valid = 0.
- busy remains 1 for exactly RAM_DEPTH cycles after the first rising edge with rst_n=1.
- busy drops to 0 in the cycle after address RAM_DEPTH-1 is written. The first accepted op is in that cycle.
- Read latency: 1 cycle.
- Write or accumulate visible to a read issued at t+1 (via forwarding) or later (via the array).
- Full throughput: one op per bank per cycle, with no stalls or back-pressure.
- Banks are fully independent. Mixed ops in one cycle are legal, for example bank0 read and bank1 accumulate.

## Structure
- Package int_ram_pkg holds:
  - clear FSM state enum {CLEAR, RUN}
  - op enum {OP_IDLE, OP_READ, OP_WRITE, OP_ACC}
  - function sat_add(a, b) parametrised by DATA_WIDTH
  - saturation limit constants
- Sub-module int_ram_bank: one 1R1W array with op decode, writeback register, forwarding mux and output register. The top instantiates it NUM_BANKS times in a generate loop.
- Top-level int_ram_banked holds only the clear FSM and sweep counter. The sweep overrides bank inputs (write, data 0, sweep address) while busy.

## Test plan
- Reset release with RAM_DEPTH=256 -> busy=1 for 256 cycles, then 0. A read of address 0xFF on both banks returns 0 with rd_valid=1 one cycle later.
- Bank0 write 7 at addr 3 at t, bank0 read addr 3 at t+1 -> data_out[0]=7 at t+2 (forwarded). Bank1 rd_valid stays 0 throughout.
- Bank1 accumulate +9 at addr 5 on three consecutive cycles, starting from 0 -> the pending values 9, 15 (saturated), 15 chain via forwarding. A later read returns 15.
- Write -15 at addr 2, then accumulate -8 -> stored value -15. A read gives data_out=-15 with no wrap.
- Simultaneous bank0 read addr 10 and bank1 write addr 10 -> bank0 returns the old value, and bank1 is updated independently.
- rst_n pulsed low at sweep address 100 -> outputs return to reset values and the sweep restarts at 0. clear_req and ops issued during busy have no effect.
